// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-cache memory arbiter: state encodings, port ids, beat width.
// Imported by mem_arb_pick and mem_arbiter.
package mem_arbiter_pkg;

    localparam int MEM_DATA_BITS = 128;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_CMD   = 2'd1;
    localparam logic [1:0] ARB_WDATA = 2'd2;
    localparam logic [1:0] ARB_RRESP = 2'd3;

    localparam logic ARB_IC = 1'b0;
    localparam logic ARB_DC = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker choosing which cache is granted next.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention using last_grant; otherwise dc beats ic.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic ic_valid,
    input  logic dc_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic winner
);

    always_comb begin
        winner = (ic_valid && !dc_valid) ? ARB_IC : ARB_DC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ic_valid && dc_valid) begin
            winner = ~last_grant;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between the instruction and data caches, locking
// the memory to one cache per transaction. MEM_ARB_ROUND_ROBIN_EN enables round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = MEM_DATA_BITS,
    parameter int READ_BEATS  = 4,
    parameter int WRITE_BEATS = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ic_mem_req_valid,
    output logic                ic_mem_req_ready,
    input  logic [ADDR_W-1:0]   ic_mem_req_addr,
    input  logic                ic_mem_req_rw,
    input  logic                ic_mem_req_data_valid,
    output logic                ic_mem_req_data_ready,
    input  logic [DATA_W-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_W/8-1:0] ic_mem_req_data_mask,
    output logic                ic_mem_resp_valid,
    output logic [DATA_W-1:0]   ic_mem_resp_data,

    input  logic                dc_mem_req_valid,
    output logic                dc_mem_req_ready,
    input  logic [ADDR_W-1:0]   dc_mem_req_addr,
    input  logic                dc_mem_req_rw,
    input  logic                dc_mem_req_data_valid,
    output logic                dc_mem_req_data_ready,
    input  logic [DATA_W-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_W/8-1:0] dc_mem_req_data_mask,
    output logic                dc_mem_resp_valid,
    output logic [DATA_W-1:0]   dc_mem_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_rw,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int MAX_BEATS = (READ_BEATS > WRITE_BEATS) ? READ_BEATS : WRITE_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1;

    logic [1:0]       state;
    logic             grant;
    logic [CNT_W-1:0] cnt;
    logic             winner;

    logic                sel_req_valid;
    logic [ADDR_W-1:0]   sel_req_addr;
    logic                sel_req_rw;
    logic                sel_data_valid;
    logic [DATA_W-1:0]   sel_data_bits;
    logic [DATA_W/8-1:0] sel_data_mask;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    mem_arb_pick u_pick (
        .ic_valid   (ic_mem_req_valid),
        .dc_valid   (dc_mem_req_valid),
        .last_grant (last_grant),
        .winner     (winner)
    );
`else
    mem_arb_pick u_pick (
        .ic_valid (ic_mem_req_valid),
        .dc_valid (dc_mem_req_valid),
        .winner   (winner)
    );
`endif

    assign sel_req_valid  = (grant == ARB_DC) ? dc_mem_req_valid      : ic_mem_req_valid;
    assign sel_req_addr   = (grant == ARB_DC) ? dc_mem_req_addr       : ic_mem_req_addr;
    assign sel_req_rw     = (grant == ARB_DC) ? dc_mem_req_rw         : ic_mem_req_rw;
    assign sel_data_valid = (grant == ARB_DC) ? dc_mem_req_data_valid : ic_mem_req_data_valid;
    assign sel_data_bits  = (grant == ARB_DC) ? dc_mem_req_data_bits  : ic_mem_req_data_bits;
    assign sel_data_mask  = (grant == ARB_DC) ? dc_mem_req_data_mask  : ic_mem_req_data_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            grant <= ARB_DC;
            cnt   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= ARB_IC;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (ic_mem_req_valid || dc_mem_req_valid) begin
                        grant <= winner;
                        state <= ARB_CMD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= winner;
`endif
                    end
                end
                ARB_CMD: begin
                    if (!sel_req_valid) begin
                        state <= ARB_IDLE;
                    end else if (mem_req_ready) begin
                        state <= sel_req_rw ? ARB_WDATA : ARB_RRESP;
                        cnt   <= '0;
                    end
                end
                ARB_WDATA: begin
                    if (sel_data_valid && mem_req_data_ready) begin
                        if (cnt == CNT_W'(WRITE_BEATS - 1)) begin
                            state <= ARB_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ARB_RRESP: begin
                    if (mem_resp_valid) begin
                        if (cnt == CNT_W'(READ_BEATS - 1)) begin
                            state <= ARB_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Read data is broadcast; only resp_valid selects the owner.
    assign ic_mem_resp_data = mem_resp_data;
    assign dc_mem_resp_data = mem_resp_data;

    always_comb begin
        mem_req_valid         = 1'b0;
        mem_req_addr          = '0;
        mem_req_rw            = 1'b0;
        mem_req_data_valid    = 1'b0;
        mem_req_data_bits     = '0;
        mem_req_data_mask     = '0;
        ic_mem_req_ready      = 1'b0;
        dc_mem_req_ready      = 1'b0;
        ic_mem_req_data_ready = 1'b0;
        dc_mem_req_data_ready = 1'b0;
        ic_mem_resp_valid     = 1'b0;
        dc_mem_resp_valid     = 1'b0;
        case (state)
            ARB_CMD: begin
                mem_req_valid    = sel_req_valid;
                mem_req_addr     = sel_req_addr;
                mem_req_rw       = sel_req_rw;
                ic_mem_req_ready = (grant == ARB_IC) && mem_req_ready;
                dc_mem_req_ready = (grant == ARB_DC) && mem_req_ready;
            end
            ARB_WDATA: begin
                mem_req_data_valid    = sel_data_valid;
                mem_req_data_bits     = sel_data_bits;
                mem_req_data_mask     = sel_data_mask;
                ic_mem_req_data_ready = (grant == ARB_IC) && mem_req_data_ready;
                dc_mem_req_data_ready = (grant == ARB_DC) && mem_req_data_ready;
            end
            ARB_RRESP: begin
                ic_mem_resp_valid = (grant == ARB_IC) && mem_resp_valid;
                dc_mem_resp_valid = (grant == ARB_DC) && mem_resp_valid;
            end
            default: begin
            end
        endcase
    end

endmodule
